// File: rtl/exp_taylor_drv.sv
// exp_taylor_drv: initiator-side sequencer for the Taylor exponent unit.
// Takes operands from a valid/ready stream and launches one evaluation at a
// time. It stops the unit early by raising uDataRead once the term budget has
// elapsed, captures the result and queues it in a small output FIFO.
// Optional feature macro: EXP_DRV_TIMEOUT_EN adds a READ-state watchdog that
// sets the sticky errTimeout flag and abandons the operand.

`ifndef FRACWIDTH
`define FRACWIDTH 12
`endif
`ifndef MAXTERM
`define MAXTERM 8
`endif

module exp_taylor_drv #(
  parameter int DW       = `FRACWIDTH,
  parameter int MAX_TERM = `MAXTERM,
  parameter int DEPTH    = 4,
  parameter int TO_SLACK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] sIn,
  input  logic [3:0]    sBudget,
  input  logic          sInValid,
  output logic          sInReady,
  input  logic [DW-1:0] cfgExp1,
  output logic [DW-1:0] uData,
  output logic [DW-1:0] uExp1,
  output logic          uDataValid,
  output logic          uDataRead,
  input  logic [DW-1:0] uResult,
  input  logic          uResultValid,
  output logic [DW-1:0] mOut,
  output logic          mOutValid,
  input  logic          mOutReady,
  output logic          busy,
  output logic          errTimeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [3:0] BE_MAX = 4'(MAX_TERM - 1);

  // Parameter sanity: the FIFO needs at least two slots and the watchdog
  // needs a positive slack; an illegal setting elaborates this empty block.
  if (DEPTH < 2 || TO_SLACK < 1) begin : g_cfg_invalid
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t        state_q;
  logic [DW-1:0] data_q;
  logic [3:0]    be_q;
  logic [3:0]    be_d;
  logic [3:0]    k_q;
  logic          uvalid_q;
  logic          uread_q;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] fifo_cnt;
  logic [DW-1:0] mem_q [DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic          timeout_hit;

  // exp1 constant goes to the unit untouched
  assign uExp1 = cfgExp1;

  // FIFO occupancy falls out of the wrapped pointer difference
  assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
  assign mOutValid = (fifo_cnt != '0);
  assign pop       = mOutValid && mOutReady;
  // Empty FIFO presents zero so mOut has a defined value after reset
  assign mOut      = mOutValid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

  // Accept only when a result slot is guaranteed, so a push never overflows
  assign sInReady = (state_q == IDLE) && (fifo_cnt < PW'(DEPTH));
  assign accept   = sInValid && sInReady;

  // Only the first uResultValid seen in READ is a genuine result; a value
  // parked high from the previous evaluation is ignored in the other states.
  assign push = (state_q == READ) && uResultValid;

  assign uData      = data_q;
  assign uDataValid = uvalid_q;
  assign uDataRead  = uread_q;
  assign busy       = (state_q != IDLE);

  // Effective budget: 0 behaves as 1, anything past the terminal count is
  // trimmed to MAX_TERM-1 (natural termination).
  always_comb begin
    be_d = sBudget;
    if (sBudget == 4'd0) begin
      be_d = 4'd1;
    end else if (sBudget > BE_MAX) begin
      be_d = BE_MAX;
    end
  end

  // Sequencer: launch, count terms, early-stop, then wait for the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      be_q     <= 4'd1;
      k_q      <= 4'd0;
      uvalid_q <= 1'b0;
      uread_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q   <= sIn;
            be_q     <= be_d;
            uvalid_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          uvalid_q <= 1'b0;
          k_q      <= 4'd1;
          if (be_q == 4'd1) begin
            uread_q <= 1'b1;
            state_q <= READ;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          k_q <= k_q + 4'd1;
          if (k_q == be_q - 4'd1) begin
            uread_q <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          if (push || timeout_hit) begin
            uread_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          uvalid_q <= 1'b0;
          uread_q  <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointers; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= uResult;
    end
  end

`ifdef EXP_DRV_TIMEOUT_EN
  localparam int WW = 8;

  logic [WW-1:0] wd_q;
  logic [WW-1:0] wd_limit;
  logic          err_q;

  // The watchdog reads n in the n-th cycle after entering READ, so the limit
  // Be+TO_SLACK-1 lands on cycle T0+2Be+TO_SLACK-1.
  assign wd_limit    = WW'(be_q) + WW'(TO_SLACK - 1);
  assign timeout_hit = (state_q == READ) && !uResultValid && (wd_q == wd_limit);
  assign errTimeout  = err_q;

  // Count READ cycles and latch the sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == READ) begin
        wd_q <= wd_q + WW'(1);
      end else begin
        wd_q <= '0;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  // Without the watchdog READ waits for the unit indefinitely
  assign timeout_hit = 1'b0;
  assign errTimeout  = 1'b0;
`endif

endmodule

// File: doc/exp_taylor_drv.md
# exp_taylor_drv

Initiator-side sequencer for the configurable Taylor exponent neuron unit. It accepts operands from an upstream valid/ready stream and launches one exponent evaluation at a time on the unit's `iDataValid` port. It applies a per-operand term budget by asserting the unit's early-stop (`oDataRead`) at the right cycle, then captures the result on `oDataValid`. Results are buffered in a small output FIFO that drains to a downstream valid/ready stream.

## Interface
Parameters:
- `DW`, default `` `FRACWIDTH `` (12): operand and result width; must match the unit.
- `MAX_TERM`, default `` `MAXTERM `` (8): the unit's terminal count value.
- `DEPTH`, default 4: result FIFO depth, power of two, at least 2.
- `TO_SLACK`, default 4: timeout slack cycles, used only with `EXP_DRV_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `sIn`, in, DW: operand, an unsigned fraction.
- `sBudget`, in, 4: term budget B, sampled with `sIn`.
- `sInValid`, in, 1: upstream valid.
- `sInReady`, out, 1: upstream ready.
- `cfgExp1`, in, DW: e^1 fraction constant, passed straight through to `uExp1`.
- `uData`, out, DW: drives unit `iData`.
- `uExp1`, out, DW: drives unit `exp1`.
- `uDataValid`, out, 1: drives unit `iDataValid`.
- `uDataRead`, out, 1: drives unit `oDataRead`.
- `uResult`, in, DW: from unit `oData`.
- `uResultValid`, in, 1: from unit `oDataValid`.
- `mOut`, out, DW: result at the FIFO head.
- `mOutValid`, out, 1: FIFO not empty.
- `mOutReady`, in, 1: downstream ready.
- `busy`, out, 1: state is not IDLE.
- `errTimeout`, out, 1: sticky timeout flag.

## Operation
- **States.** IDLE, ISSUE, RUN, READ.
- **Accept.** `sInReady` = (state==IDLE) && (fifo count < DEPTH).
  - On `sInValid && sInReady`: register `sIn` into `uData`.
  - Register the effective budget Be = clamp(`sBudget`, 1, MAX_TERM-1).
  - Next state is ISSUE.
- **ISSUE.** Lasts exactly 1 cycle and `uDataValid`=1.
  - Go to READ if Be==1, else go to RUN.
  - Load the term counter k=1.
- **RUN.** k increments each cycle. When k==Be-1, go to READ.
- **READ.** `uDataRead`=1 for the whole state.
  - On the first cycle with `uResultValid`=1, write `uResult` into the FIFO and go to IDLE.
- **Hold rules.**
  - `uData` holds its value outside accept; the unit samples it only in ISSUE.
  - `uResultValid` seen in IDLE, ISSUE or RUN is ignored. The unit holds it high while parked at its terminal count.
- **FIFO.**
  - Pointers are log2(DEPTH)+1 bits wide and wrap naturally.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pop happens on `mOutValid && mOutReady`.
  - Because accept is admitted only when count < DEPTH, a push never meets a full FIFO.
- **`errTimeout`.** Set as described under Configuration; cleared only by reset.

## Timing
- T0 is the ISSUE cycle. The accept edge is the edge ending cycle T0-1.
- `uDataRead`=1 in cycles T0+Be through the capture cycle.
- Nominal capture is at cycle T0+Be+2, with the FIFO written at the end of that cycle. `mOutValid` rises in T0+Be+3 if the FIFO was empty.
- The next accept is possible in T0+Be+3, so the throughput is one operand per Be+4 cycles.
- Budget edge cases: Be=MAX_TERM-1 is natural termination; `sBudget` 0 behaves as 1; `sBudget` of MAX_TERM or more behaves as MAX_TERM-1.
- Reset values:
  - state is IDLE;
  - `uData` is 0; `uDataValid`, `uDataRead` and `busy` are 0;
  - FIFO is empty, so `mOutValid` is 0 and `mOut` is 0;
  - `errTimeout` is 0;
  - `sInReady` is 1.
- Reset mid-operation aborts the evaluation and discards both the in-flight operand and the buffered results.
- `uExp1` is combinational from `cfgExp1`; `cfgExp1` must be static while `busy`=1.

## Configuration
- Macro `EXP_DRV_TIMEOUT_EN`.
- **Defined:** a watchdog counts the cycles spent in READ.
  - If the count reaches Be+`TO_SLACK`-1 with no `uResultValid`, then at the end of cycle T0+2Be+`TO_SLACK`-1 set `errTimeout`, deassert `uDataRead`, and return to IDLE with no FIFO write.
  - With the defaults, a timeout fires when no result arrives by T0+2Be+3.
- **Undefined:** no watchdog logic; `errTimeout` is tied to 0 and READ waits indefinitely.

## Test plan
- Single op, behavioural unit model, `sIn`=0x400, `sBudget`=3:
  - `uDataValid` high in T0 only, with `uData`=0x400;
  - `uDataRead` high in T0+3 through T0+5;
  - `mOut` equals the model result, with `mOutValid` rising at T0+6.
- Budget clamping, `sBudget`=0 and then 15:
  - `uDataRead` rises at T0+1 for the first operand;
  - `uDataRead` rises at T0+7 for the second operand (MAX_TERM=8).
- Back-pressure, `mOutReady`=0, DEPTH=4, with 5 operands offered back to back:
  - 4 results are buffered and `sInReady` stays 0;
  - raising `mOutReady` for 1 cycle pops a result, then the 5th operand is accepted.
- Simultaneous push and pop, `mOutReady`=1 with a continuous stream of operands:
  - FIFO count never exceeds 1;
  - results come out in order, with no loss or duplication.
- Timeout (`EXP_DRV_TIMEOUT_EN`, `TO_SLACK`=4), model never asserts `uResultValid`, `sBudget`=2:
  - `errTimeout`=1 from T0+8 on;
  - `busy`=0 and FIFO still empty.
- Reset asserted in RUN with 2 results buffered:
  - all outputs immediately show their reset values, asynchronously;
  - after release, `sInReady`=1.
